// File: rtl/envio_serial_automatico_uc_pkg.sv
// Shared definitions for the automatic serial-dump control unit:
// FSM state encodings and the number of words sent per frame.
package envio_serial_automatico_uc_pkg;

    localparam int N_CONTEUDO = 7;
    localparam int N_FILA     = 15;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        ZERA     = 4'd2,
        PREP_C   = 4'd3,
        ENVIA_C  = 4'd4,
        ESPERA_C = 4'd5,
        PROX_C   = 4'd6,
        PREP_F   = 4'd7,
        ENVIA_F  = 4'd8,
        ESPERA_F = 4'd9,
        PROX_F   = 4'd10,
        ABORTA   = 4'd11,
        FIM      = 4'd12
    } estado_t;

    function automatic logic ehOcupado(input estado_t e);
        return (e >= ZERA) && (e <= FIM);
    endfunction

endpackage

// File: rtl/envio_serial_automatico_uc_if.sv
// Handshake bundle between the serial-dump control unit (slave) and
// its datapath/transmitter side (master).
interface envio_serial_automatico_uc_if;

    logic       ligar;
    logic       envia_agora;
    logic       enviado;
    logic       fim_conteudo;
    logic       fim_fila;
    logic       zera_enderecos;
    logic       eh_conteudo_elevador;
    logic       conta_conteudo_elevador;
    logic       conta_fila_elevador;
    logic       envia_serial;
    logic       ocupado;
    logic       fim_quadro;
    logic       erro_timeout;
    logic [3:0] db_estado;

    modport slave (
        input  ligar, envia_agora, enviado, fim_conteudo, fim_fila,
        output zera_enderecos, eh_conteudo_elevador, conta_conteudo_elevador,
               conta_fila_elevador, envia_serial, ocupado, fim_quadro,
               erro_timeout, db_estado
    );

    modport master (
        output ligar, envia_agora, enviado, fim_conteudo, fim_fila,
        input  zera_enderecos, eh_conteudo_elevador, conta_conteudo_elevador,
               conta_fila_elevador, envia_serial, ocupado, fim_quadro,
               erro_timeout, db_estado
    );

endinterface

// File: rtl/envio_serial_automatico_uc_timer_espera.sv
// Saturating up-counter with synchronous clear and enable; flags when the
// count reaches TERMINAL-1 and then holds there instead of wrapping.
module envio_serial_automatico_uc_timer_espera #(
    parameter int TERMINAL = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_limpa,
    input  logic i_habilita,
    output logic o_terminal
);

    localparam int W = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;
    localparam logic [W-1:0] ULTIMO = W'(TERMINAL - 1);

    logic [W-1:0] r_contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (i_limpa) begin
            r_contagem <= '0;
        end else if (i_habilita && (r_contagem != ULTIMO)) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign o_terminal = (r_contagem == ULTIMO);

endmodule

// File: rtl/envio_serial_automatico_uc.sv
// Control unit for the automatic serial dump: per frame, 7 content words
// then 15 queue words, started periodically or on demand.
module envio_serial_automatico_uc
    import envio_serial_automatico_uc_pkg::*;
#(
    parameter int PERIODO    = 50_000_000,
    parameter int TIMEOUT_TX = 2_000_000
) (
    input  logic                         clock,
    input  logic                         reset,
    envio_serial_automatico_uc_if.slave  bus
);

    estado_t r_estado;
    estado_t w_proximo;

    logic w_fimPeriodo;
    logic w_fimTx;
    logic w_habilitaPeriodo;
    logic w_habilitaTx;

    logic r_zera;
    logic r_ehConteudo;
    logic r_contaConteudo;
    logic r_contaFila;
    logic r_envia;
    logic r_ocupado;
    logic r_fimQuadro;
    logic r_erro;

    // Period timer only runs while idle with periodic mode on.
    assign w_habilitaPeriodo = (r_estado == ESPERA);
    assign w_habilitaTx      = (r_estado == ESPERA_C) || (r_estado == ESPERA_F);

    envio_serial_automatico_uc_timer_espera #(.TERMINAL(PERIODO)) u_timerPeriodo (
        .clock      (clock),
        .reset      (reset),
        .i_limpa    (!w_habilitaPeriodo || !bus.ligar),
        .i_habilita (w_habilitaPeriodo),
        .o_terminal (w_fimPeriodo)
    );

    envio_serial_automatico_uc_timer_espera #(.TERMINAL(TIMEOUT_TX)) u_timerTx (
        .clock      (clock),
        .reset      (reset),
        .i_limpa    (!w_habilitaTx),
        .i_habilita (w_habilitaTx),
        .o_terminal (w_fimTx)
    );

    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:  w_proximo = ESPERA;
            ESPERA:   w_proximo = ((bus.ligar && w_fimPeriodo) || bus.envia_agora) ? ZERA : ESPERA;
            ZERA:     w_proximo = PREP_C;
            PREP_C:   w_proximo = ENVIA_C;
            ENVIA_C:  w_proximo = ESPERA_C;
            ESPERA_C: begin
                if (bus.enviado)      w_proximo = bus.fim_conteudo ? PREP_F : PROX_C;
                else if (w_fimTx)     w_proximo = ABORTA;
                else                  w_proximo = ESPERA_C;
            end
            PROX_C:   w_proximo = PREP_C;
            PREP_F:   w_proximo = ENVIA_F;
            ENVIA_F:  w_proximo = ESPERA_F;
            ESPERA_F: begin
                if (bus.enviado)      w_proximo = bus.fim_fila ? FIM : PROX_F;
                else if (w_fimTx)     w_proximo = ABORTA;
                else                  w_proximo = ESPERA_F;
            end
            PROX_F:   w_proximo = PREP_F;
            ABORTA:   w_proximo = FIM;
            FIM:      w_proximo = ESPERA;
            default:  w_proximo = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_estado.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado        <= INICIAL;
            r_zera          <= 1'b0;
            r_ehConteudo    <= 1'b0;
            r_contaConteudo <= 1'b0;
            r_contaFila     <= 1'b0;
            r_envia         <= 1'b0;
            r_ocupado       <= 1'b0;
            r_fimQuadro     <= 1'b0;
            r_erro          <= 1'b0;
        end else begin
            r_estado        <= w_proximo;
            r_zera          <= (w_proximo == ZERA);
            r_ehConteudo    <= (w_proximo inside {PREP_C, ENVIA_C, ESPERA_C, PROX_C});
            r_contaConteudo <= (w_proximo == PROX_C);
            r_contaFila     <= (w_proximo == PROX_F);
            r_envia         <= (w_proximo == ENVIA_C) || (w_proximo == ENVIA_F);
            r_ocupado       <= ehOcupado(w_proximo);
            r_fimQuadro     <= (w_proximo == FIM);
            if (w_proximo == ZERA) begin
                r_erro <= 1'b0;
            end else if (w_proximo == ABORTA) begin
                r_erro <= 1'b1;
            end
        end
    end

    assign bus.zera_enderecos          = r_zera;
    assign bus.eh_conteudo_elevador    = r_ehConteudo;
    assign bus.conta_conteudo_elevador = r_contaConteudo;
    assign bus.conta_fila_elevador     = r_contaFila;
    assign bus.envia_serial            = r_envia;
    assign bus.ocupado                 = r_ocupado;
    assign bus.fim_quadro              = r_fimQuadro;
    assign bus.erro_timeout            = r_erro;
    assign bus.db_estado               = r_estado;

endmodule

// File: tb/tb_envio_serial_automatico_uc.sv
// Scoreboard bench for the serial-dump control unit: a datapath/transmitter
// model answers the DUT, and a monitor matches each frame event to a queue.
module tb_envio_serial_automatico_uc;
    import envio_serial_automatico_uc_pkg::*;

    localparam int PERIODO_TB = 10;
    localparam int TIMEOUT_TB = 8;

    typedef struct {
        int   tipo;      // 0 zera, 1 envio, 2 fim
        int   eh;
        int   endereco;
        int   erro;
        int   nConta;
        int   nFila;
    } evento_t;

    logic clock = 1'b0;
    logic reset;

    envio_serial_automatico_uc_if bus();

    envio_serial_automatico_uc #(
        .PERIODO    (PERIODO_TB),
        .TIMEOUT_TX (TIMEOUT_TB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    evento_t esperado[$];
    int checks = 0;
    int errors = 0;

    int enderecoC = 0;
    int enderecoF = 0;
    int txAtraso = 3;
    bit txMudo = 1'b0;
    bit txPendente = 1'b0;
    int txEspera = 0;
    int nConta = 0;
    int nFila = 0;

    task automatic checkOutput(input string nome, input int atual, input int exigido);
        checks++;
        if (atual != exigido) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", nome, atual, exigido);
        end
    endtask

    task automatic pushEvento(input int tipo, input int eh, input int endereco,
                              input int erro, input int nc, input int nf);
        evento_t e;
        e.tipo = tipo; e.eh = eh; e.endereco = endereco;
        e.erro = erro; e.nConta = nc; e.nFila = nf;
        esperado.push_back(e);
    endtask

    // Expected frame: zera, nC content sends, nF queue sends, optional end.
    task automatic pushQuadro(input int nC, input int nF, input bit comFim,
                              input int erro, input int nc, input int nf);
        pushEvento(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < nC; i++) pushEvento(1, 1, i, 0, 0, 0);
        for (int i = 0; i < nF; i++) pushEvento(1, 0, i, 0, 0, 0);
        if (comFim) pushEvento(2, 0, 0, erro, nc, nf);
    endtask

    task automatic applyStimulus(input bit ligarNovo, input bit pulso);
        @(negedge clock);
        bus.ligar = ligarNovo;
        if (pulso) begin
            bus.envia_agora = 1'b1;
            @(negedge clock);
            bus.envia_agora = 1'b0;
        end
    endtask

    task automatic aguardarFim(input int limite, input string nome);
        bit visto = 1'b0;
        for (int i = 0; i < limite && !visto; i++) begin
            @(negedge clock);
            visto = bus.fim_quadro;
        end
        if (!visto) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no fim_quadro expected one within %0d cycles", nome, limite);
        end
    endtask

    task automatic checkFilaVazia(input string nome);
        checkOutput(nome, esperado.size(), 0);
        esperado.delete();
    endtask

    // Datapath address counters and transmitter with a programmable done delay.
    initial begin
        bus.enviado      = 1'b0;
        bus.fim_conteudo = 1'b0;
        bus.fim_fila     = 1'b0;
        forever begin
            @(negedge clock);
            bus.enviado = 1'b0;
            if (reset) begin
                enderecoC  = 0;
                enderecoF  = 0;
                txPendente = 1'b0;
            end else begin
                if (bus.zera_enderecos) begin
                    enderecoC = 0;
                    enderecoF = 0;
                end
                if (bus.conta_conteudo_elevador) enderecoC++;
                if (bus.conta_fila_elevador) enderecoF++;
                if (txPendente) begin
                    txEspera--;
                    if (txEspera == 0) begin
                        bus.enviado = 1'b1;
                        txPendente  = 1'b0;
                    end
                end
                if (bus.envia_serial && !txMudo) begin
                    txPendente = 1'b1;
                    txEspera   = txAtraso;
                end
            end
            bus.fim_conteudo = (enderecoC == N_CONTEUDO - 1);
            bus.fim_fila     = (enderecoF == N_FILA - 1);
        end
    end

    // Monitor: every zera/envio/fim pops one expected event and compares it.
    initial begin
        evento_t e;
        int tipo;
        forever begin
            @(negedge clock);
            if (reset) begin
                nConta = 0;
                nFila  = 0;
            end else begin
                if (bus.zera_enderecos) begin
                    nConta = 0;
                    nFila  = 0;
                end
                if (bus.conta_conteudo_elevador) nConta++;
                if (bus.conta_fila_elevador) nFila++;
                if (bus.zera_enderecos || bus.envia_serial || bus.fim_quadro) begin
                    tipo = bus.zera_enderecos ? 0 : (bus.envia_serial ? 1 : 2);
                    if (esperado.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_event: got type %0d expected none", tipo);
                    end else begin
                        e = esperado.pop_front();
                        checkOutput("event_type", tipo, e.tipo);
                        if (tipo == e.tipo) begin
                            checkOutput("ocupado_in_frame", int'(bus.ocupado), 1);
                            case (tipo)
                                0: checkOutput("erro_cleared_at_zera", int'(bus.erro_timeout), 0);
                                1: begin
                                    checkOutput("eh_conteudo", int'(bus.eh_conteudo_elevador), e.eh);
                                    checkOutput("word_address",
                                                bus.eh_conteudo_elevador ? enderecoC : enderecoF,
                                                e.endereco);
                                end
                                default: begin
                                    checkOutput("erro_at_fim", int'(bus.erro_timeout), e.erro);
                                    checkOutput("conta_conteudo_pulses", nConta, e.nConta);
                                    checkOutput("conta_fila_pulses", nFila, e.nFila);
                                end
                            endcase
                        end
                    end
                end
            end
        end
    end

    initial begin
        int gap;
        int nEspera;
        bit achou;

        reset           = 1'b1;
        bus.ligar       = 1'b0;
        bus.envia_agora = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("reset_zera", int'(bus.zera_enderecos), 0);
        checkOutput("reset_envia", int'(bus.envia_serial), 0);
        checkOutput("reset_ocupado", int'(bus.ocupado), 0);
        checkOutput("reset_fim", int'(bus.fim_quadro), 0);
        checkOutput("reset_erro", int'(bus.erro_timeout), 0);
        checkOutput("reset_db_estado", int'(bus.db_estado), 0);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("after_reset_espera", int'(bus.db_estado), 1);

        // Periodic frame, then the idle gap before the next one
        pushQuadro(7, 15, 1'b1, 0, 6, 14);
        applyStimulus(1'b1, 1'b0);
        aguardarFim(400, "periodic_frame");
        pushQuadro(7, 15, 1'b1, 0, 6, 14);
        gap = 0;
        achou = 1'b0;
        for (int i = 0; i < 50 && !achou; i++) begin
            @(negedge clock);
            if (bus.zera_enderecos) achou = 1'b1;
            else gap++;
        end
        checkOutput("idle_gap_cycles", gap, PERIODO_TB);

        // envia_agora during a frame and ligar dropped mid-queue
        achou = 1'b0;
        for (int i = 0; i < 50 && !achou; i++) begin
            @(negedge clock);
            achou = (bus.db_estado == 4'd5);
        end
        checkOutput("reached_espera_c", int'(achou), 1);
        applyStimulus(1'b1, 1'b1);
        achou = 1'b0;
        for (int i = 0; i < 300 && !achou; i++) begin
            @(negedge clock);
            achou = (bus.db_estado == 4'd9) && (enderecoF == 7);
        end
        checkOutput("reached_queue_word7", int'(achou), 1);
        bus.ligar = 1'b0;
        aguardarFim(300, "frame_ligar_dropped");
        @(negedge clock);
        checkOutput("ocupado_after_fim", int'(bus.ocupado), 0);
        checkOutput("espera_after_fim", int'(bus.db_estado), 1);
        repeat (100) @(negedge clock);
        checkFilaVazia("no_second_frame");

        // On-demand frame with periodic mode off
        pushQuadro(7, 15, 1'b1, 0, 6, 14);
        applyStimulus(1'b0, 1'b1);
        aguardarFim(400, "on_demand_frame");
        repeat (100) @(negedge clock);
        checkOutput("idle_after_demand", int'(bus.db_estado), 1);
        checkFilaVazia("on_demand_single_frame");

        // Transmitter never answers: abort after TIMEOUT_TB waiting cycles
        txMudo = 1'b1;
        pushQuadro(1, 0, 1'b1, 1, 0, 0);
        applyStimulus(1'b0, 1'b1);
        achou = 1'b0;
        for (int i = 0; i < 20 && !achou; i++) begin
            @(negedge clock);
            achou = bus.envia_serial;
        end
        checkOutput("timeout_envia_seen", int'(achou), 1);
        nEspera = 0;
        achou = 1'b0;
        for (int i = 0; i < 20 && !achou; i++) begin
            @(negedge clock);
            if (bus.db_estado == 4'd5) nEspera++;
            else achou = 1'b1;
        end
        checkOutput("timeout_wait_cycles", nEspera, TIMEOUT_TB);
        checkOutput("aborta_state", int'(bus.db_estado), 11);
        checkOutput("aborta_erro", int'(bus.erro_timeout), 1);
        aguardarFim(10, "aborted_frame");
        @(negedge clock);
        checkOutput("erro_sticky", int'(bus.erro_timeout), 1);
        checkFilaVazia("aborted_frame_events");
        txMudo = 1'b0;

        // enviado on the same cycle as the timeout terminal count
        txAtraso = TIMEOUT_TB;
        pushQuadro(7, 15, 1'b1, 0, 6, 14);
        applyStimulus(1'b0, 1'b1);
        aguardarFim(600, "enviado_vs_timeout_frame");
        @(negedge clock);
        checkOutput("erro_after_tie", int'(bus.erro_timeout), 0);
        checkFilaVazia("tie_frame_events");
        txAtraso = 3;

        // Asynchronous reset while waiting on queue word 5
        pushQuadro(7, 6, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1);
        achou = 1'b0;
        for (int i = 0; i < 300 && !achou; i++) begin
            @(negedge clock);
            achou = (bus.db_estado == 4'd9) && (enderecoF == 5);
        end
        checkOutput("reached_queue_word5", int'(achou), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_db_estado", int'(bus.db_estado), 0);
        checkOutput("async_ocupado", int'(bus.ocupado), 0);
        checkOutput("async_eh_conteudo", int'(bus.eh_conteudo_elevador), 0);
        checkOutput("async_envia", int'(bus.envia_serial), 0);
        checkFilaVazia("partial_frame_events");
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        pushQuadro(7, 15, 1'b1, 0, 6, 14);
        applyStimulus(1'b0, 1'b1);
        aguardarFim(400, "frame_after_reset");
        @(negedge clock);
        checkFilaVazia("frame_after_reset_events");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
